// File: rtl/spdif_pkg.sv
// spdif_pkg: shared sample width, silence value, underrun counter width and {R,L} packing helper
package spdif_pkg;
  localparam int SAMPLE_W = 32;
  localparam logic [SAMPLE_W-1:0] SILENCE = '0;
  localparam int UNDERRUN_CNT_W = 16;
  function automatic logic [SAMPLE_W-1:0] pack_sample(input logic [15:0] right, input logic [15:0] left);
    return {right, left};
  endfunction
endpackage

// File: rtl/spdif_sample_ram.sv
// spdif_sample_ram: simple dual-port sample storage, synchronous write, asynchronous read
// clk_i clock; wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i/rd_data_o combinational read port
module spdif_sample_ram
  import spdif_pkg::*;
#(
  parameter int DEPTH_W = 6,
  parameter int DATA_W  = SAMPLE_W
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [DEPTH_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic [DEPTH_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0]  rd_data_o
);
  logic [DATA_W-1:0] mem_q [2**DEPTH_W];
  always_ff @(posedge clk_i) if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/spdif_sample_fifo.sv
// spdif_sample_fifo: show-ahead stereo sample buffer feeding the SPDIF transmitter, with underrun handling
// clk_i/rst_i clock and sync reset; flush_i drops all samples; wr_data_i/wr_valid_i/wr_accept_o producer port;
// sample_req_i/sample_o transmitter port; level_o/low_o fill status; underrun_o/underrun_clr_i/underrun_cnt_o underrun status
module spdif_sample_fifo
  import spdif_pkg::*;
#(
  parameter int DEPTH_W         = 6,
  parameter int LOW_LEVEL       = 16,
  parameter bit UNDERRUN_REPEAT = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [SAMPLE_W-1:0]       wr_data_i,
  input  logic                      wr_valid_i,
  output logic                      wr_accept_o,
  input  logic                      sample_req_i,
  output logic [SAMPLE_W-1:0]       sample_o,
  output logic [DEPTH_W:0]          level_o,
  output logic                      low_o,
  output logic                      underrun_o,
  input  logic                      underrun_clr_i,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
);
  localparam int CW = DEPTH_W + 1;
  localparam logic [CW-1:0] FULL = CW'(2**DEPTH_W);
  logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d, level_q, level_d;
  logic [SAMPLE_W-1:0] out_q, out_d, rd_data;
  logic out_valid_q, out_valid_d, low_q, ur_q, ur_d, wr_en, pop, drain;
  logic [UNDERRUN_CNT_W-1:0] cnt_q, cnt_d;
  spdif_sample_ram #(.DEPTH_W(DEPTH_W), .DATA_W(SAMPLE_W)) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(wr_data_i),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(rd_data)
  );
  assign wr_accept_o = (count_q != FULL) && !flush_i;
  // pop covers a request on a valid output, a request during underrun and an idle refill alike;
  // drain is a request that empties the output register because storage has nothing left
  always_comb begin
    wr_en = wr_valid_i && wr_accept_o;
    pop = !flush_i && (count_q != '0) && (sample_req_i || !out_valid_q);
    drain = !flush_i && sample_req_i && out_valid_q && !pop;
    ur_d = !flush_i && sample_req_i && !out_valid_q;
    out_valid_d = flush_i ? 1'b0 : pop ? 1'b1 : drain ? 1'b0 : out_valid_q;
    out_d = flush_i ? SILENCE : pop ? rd_data : (drain && !UNDERRUN_REPEAT) ? SILENCE : out_q;
    count_d = flush_i ? '0 : count_q + CW'(wr_en) - CW'(pop);
    level_d = count_d + CW'(out_valid_d);
    cnt_d = ur_d ? (underrun_clr_i ? UNDERRUN_CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + UNDERRUN_CNT_W'(1))
                 : underrun_clr_i ? '0 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_q <= SILENCE;
      out_valid_q <= 1'b0;
      level_q <= '0;
      low_q <= (LOW_LEVEL > 0);
      ur_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= flush_i ? '0 : wr_ptr_q + DEPTH_W'(wr_en);
      rd_ptr_q <= flush_i ? '0 : rd_ptr_q + DEPTH_W'(pop);
      count_q <= count_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      level_q <= level_d;
      low_q <= int'(level_d) < LOW_LEVEL;
      ur_q <= ur_d;
      cnt_q <= cnt_d;
    end
  end
  assign sample_o = out_q;
  assign level_o = level_q;
  assign low_o = low_q;
  assign underrun_o = ur_q;
  assign underrun_cnt_o = cnt_q;
endmodule

// File: tb/tb_spdif_sample_fifo.sv
// tb_spdif_sample_fifo: table vectors, corner sequences and random traffic against a queue-based model
module tb_spdif_sample_fifo;
  import spdif_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, wv, req, clr;
  logic [31:0] wd;
  logic acc0, acc1, ur0, ur1, low0, low1;
  logic [31:0] s0, s1;
  logic [6:0] lv0, lv1;
  logic [15:0] c0, c1;
  always #5 clk = ~clk;
  spdif_sample_fifo #(.DEPTH_W(6), .LOW_LEVEL(16), .UNDERRUN_REPEAT(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_data_i(wd), .wr_valid_i(wv), .wr_accept_o(acc0),
    .sample_req_i(req), .sample_o(s0), .level_o(lv0), .low_o(low0), .underrun_o(ur0),
    .underrun_clr_i(clr), .underrun_cnt_o(c0)
  );
  spdif_sample_fifo #(.DEPTH_W(6), .LOW_LEVEL(16), .UNDERRUN_REPEAT(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_data_i(wd), .wr_valid_i(wv), .wr_accept_o(acc1),
    .sample_req_i(req), .sample_o(s1), .level_o(lv1), .low_o(low1), .underrun_o(ur1),
    .underrun_clr_i(clr), .underrun_cnt_o(c1)
  );
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 1'b1;
  logic [31:0] q[$];
  logic [31:0] m_out0 = '0, m_out1 = '0;
  bit m_valid = 1'b0, m_ur = 1'b0;
  int m_cnt = 0;
  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic check_model();
    int lvl;
    lvl = q.size() + int'(m_valid);
    check("sample0", s0, m_out0);
    check("sample1", s1, m_out1);
    check("level0", 32'(lv0), 32'(lvl));
    check("level1", 32'(lv1), 32'(lvl));
    check("low0", 32'(low0), 32'(lvl < 16));
    check("low1", 32'(low1), 32'(lvl < 16));
    check("underrun0", 32'(ur0), 32'(m_ur));
    check("underrun1", 32'(ur1), 32'(m_ur));
    check("ucnt0", 32'(c0), 32'(m_cnt));
    check("ucnt1", 32'(c1), 32'(m_cnt));
  endtask
  task automatic cyc(bit f, bit w, logic [31:0] d, bit r, bit c);
    bit acc;
    logic [31:0] s;
    @(negedge clk);
    flush = f; wv = w; wd = d; req = r; clr = c;
    #1;
    acc = (q.size() != 64) && !f;
    if (chk_on) begin
      check("accept0", 32'(acc0), 32'(acc));
      check("accept1", 32'(acc1), 32'(acc));
    end
    m_ur = !f && r && !m_valid;
    m_cnt = m_ur ? (c ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1)) : (c ? 0 : m_cnt);
    if (f) begin
      q.delete();
      m_valid = 1'b0;
      m_out0 = '0;
      m_out1 = '0;
    end else begin
      if (q.size() > 0 && (r || !m_valid)) begin
        s = q.pop_front();
        m_out0 = s;
        m_out1 = s;
        m_valid = 1'b1;
      end else if (r && m_valid) begin
        m_valid = 1'b0;
        m_out0 = '0;
      end
      if (w && acc) q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (chk_on) check_model();
  endtask
  typedef struct {
    bit w;
    logic [31:0] d;
    bit r;
    int idle;
    logic [31:0] e_s0;
    logic [31:0] e_s1;
    int e_lv;
    bit e_ur;
    int e_cnt;
  } vec_t;
  vec_t tv[8];
  initial begin
    tv[0] = '{1'b1, pack_sample(16'h0001, 16'h0002), 1'b0, 0,   32'h0,        32'h0,        1, 1'b0, 0};
    tv[1] = '{1'b1, pack_sample(16'h0003, 16'h0004), 1'b0, 0,   32'h00010002, 32'h00010002, 2, 1'b0, 0};
    tv[2] = '{1'b1, pack_sample(16'h0005, 16'h0006), 1'b0, 0,   32'h00010002, 32'h00010002, 3, 1'b0, 0};
    tv[3] = '{1'b0, 32'h0,                           1'b1, 127, 32'h00030004, 32'h00030004, 2, 1'b0, 0};
    tv[4] = '{1'b0, 32'h0,                           1'b1, 127, 32'h00050006, 32'h00050006, 1, 1'b0, 0};
    tv[5] = '{1'b0, 32'h0,                           1'b1, 127, 32'h0,        32'h00050006, 0, 1'b0, 0};
    tv[6] = '{1'b0, 32'h0,                           1'b1, 0,   32'h0,        32'h00050006, 0, 1'b1, 1};
    tv[7] = '{1'b0, 32'h0,                           1'b0, 0,   32'h0,        32'h00050006, 0, 1'b0, 1};
    rst = 1'b1; flush = 1'b0; wv = 1'b0; wd = '0; req = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample", s0, 32'h0);
    check("rst_level", 32'(lv0), 32'h0);
    check("rst_low", 32'(low0), 32'h1);
    check("rst_underrun", 32'(ur0), 32'h0);
    check("rst_ucnt", 32'(c0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_accept", 32'(acc0), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, tv[i].w, tv[i].d, tv[i].r, 1'b0);
      check($sformatf("vec%0d_s0", i), s0, tv[i].e_s0);
      check($sformatf("vec%0d_s1", i), s1, tv[i].e_s1);
      check($sformatf("vec%0d_level", i), 32'(lv0), 32'(tv[i].e_lv));
      check($sformatf("vec%0d_underrun", i), 32'(ur0), 32'(tv[i].e_ur));
      check($sformatf("vec%0d_ucnt", i), 32'(c0), 32'(tv[i].e_cnt));
      repeat (tv[i].idle) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 70; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
    check("full_level", 32'(lv0), 32'd65);
    check("full_accept", 32'(acc0), 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("pop_level", 32'(lv0), 32'd64);
    cyc(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    check("wr_pop_level", 32'(lv0), 32'd64);
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    check("flush_level", 32'(lv0), 32'h0);
    check("flush_sample", s0, 32'h0);
    check("flush_underrun", 32'(ur0), 32'h0);
    cyc(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("refill_latency", s0, 32'hA5A5_0001);
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 500) % 2 == 1) ? 85 : 30;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < wp, $urandom,
          $urandom_range(0, 99) < 50, $urandom_range(0, 49) == 0);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_on = 1'b0;
    repeat (70000) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_on = 1'b1;
    check("sat_ucnt0", 32'(c0), 32'hFFFF);
    check("sat_ucnt1", 32'(c1), 32'hFFFF);
    check("sat_underrun", 32'(ur0), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("clr_with_underrun", 32'(c0), 32'h1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("clr_alone", 32'(c0), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
